// File: rtl/bus_bridge_pkg.sv
// bus_bridge_pkg: shared state encodings and error bit indices for the bus bridge.
package bus_bridge_pkg;
    localparam logic [0:0] C_BB_IDLE = 1'b0;
    localparam logic [0:0] C_BB_BUSY = 1'b1;
    localparam int C_BB_ERR_TIMEOUT = 0;
    localparam int C_BB_ERR_WPROT = 1;
endpackage

// File: rtl/bus_bridge_waitcnt.sv
// bb_waitcnt: 8-bit wait-state counter with clear, enable and terminal flag at P_TIMEOUT-1.
module bb_waitcnt #(
    parameter logic [7:0] P_TIMEOUT = 8'd16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);
    logic [7:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clr ? 8'd0 : en ? cnt_q + 8'd1 : cnt_q;
        term = cnt_q == P_TIMEOUT - 8'd1;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 8'd0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/bus_bridge.sv
// bus_bridge: mc6502 core to req/ack memory bridge with wait-state timeout and sticky errors.
// Optional write protection above P_ROM_BASE is enabled by BUS_BRIDGE_ROM_PROTECT_EN.
module bus_bridge
    import bus_bridge_pkg::*;
#(
    parameter logic [7:0]  P_TIMEOUT  = 8'd16,
    parameter logic [7:0]  P_OPEN_BUS = 8'hff,
    parameter logic [15:0] P_ROM_BASE = 16'hf000
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [7:0]  ABL,
    input  logic [7:0]  ABH,
    input  logic [7:0]  DB_OUT,
    output logic [7:0]  DB_IN,
    output logic        RDY,
    input  logic        ERR_CLR,
    output logic [1:0]  ERR,
    output logic [15:0] MEM_ADDR,
    output logic [7:0]  MEM_WDATA,
    output logic        MEM_WE,
    output logic        MEM_REQ,
    input  logic        MEM_ACK,
    input  logic [7:0]  MEM_RDATA
);
`ifdef BUS_BRIDGE_ROM_PROTECT_EN
    localparam logic C_ROM_EN = 1'b1;
`else
    localparam logic C_ROM_EN = 1'b0;
`endif
    logic [0:0]  state_q, state_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  db_in_q, db_in_d;
    logic [1:0]  err_q, err_d, err_set;
    logic        idle, busy, wp, start, wp_hit, ack, tmo, term;
    bb_waitcnt #(.P_TIMEOUT(P_TIMEOUT)) u_waitcnt (
        .clk  (CLK),
        .rst  (RES),
        .clr  (start),
        .en   (busy),
        .term (term)
    );
    always_comb begin
        idle = state_q == C_BB_IDLE;
        busy = state_q == C_BB_BUSY;
        wp = C_ROM_EN && CPU_WE && ({ABH, ABL} >= P_ROM_BASE);
        start = idle && CPU_REQ && !wp;
        wp_hit = idle && CPU_REQ && wp;
        ack = busy && MEM_ACK;
        // an ack arriving on the terminal edge completes normally instead of aborting
        tmo = busy && !MEM_ACK && term;
        state_d = start ? C_BB_BUSY : (ack || tmo) ? C_BB_IDLE : state_q;
        mem_addr_d = start ? {ABH, ABL} : mem_addr_q;
        mem_wdata_d = start ? DB_OUT : mem_wdata_q;
        mem_we_d = start ? CPU_WE : (ack || tmo) ? 1'b0 : mem_we_q;
        db_in_d = (ack && !mem_we_q) ? MEM_RDATA : (tmo && !mem_we_q) ? P_OPEN_BUS : db_in_q;
        err_set = 2'b00;
        err_set[C_BB_ERR_TIMEOUT] = tmo;
        err_set[C_BB_ERR_WPROT] = wp_hit;
        err_d = (ERR_CLR ? 2'b00 : err_q) | err_set;
    end
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= C_BB_IDLE;
            mem_addr_q <= 16'h0000;
            mem_wdata_q <= 8'h00;
            mem_we_q <= 1'b0;
            db_in_q <= 8'h00;
            err_q <= 2'b00;
        end else begin
            state_q <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q <= mem_we_d;
            db_in_q <= db_in_d;
            err_q <= err_d;
        end
    end
    assign RDY = idle;
    assign MEM_REQ = busy;
    assign MEM_ADDR = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign MEM_WE = mem_we_q;
    assign DB_IN = db_in_q;
    assign ERR = err_q;
endmodule
